test_mac: RTL and testbench
===========================

# test_mac

Single processing element (PE) of the systolic matrix-multiply array. Each clock it forwards its A operand east and its B operand south through one register stage, and adds A_in × B_in into a local accumulator. PEs are chained A_out→A_in and B_out→B_in, so operands skew by one cycle per hop. C_out exposes the running dot-product of the PE.

## Interface
- DATA_WIDTH, default 32: width of the operands, the forwarded operands and the accumulator.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; asynchronous, active-low. Assertion clears all state immediately; release is sampled on clk.
- A_in  input  DATA_WIDTH  row operand from the west neighbour or array edge.
- B_in  input  DATA_WIDTH  column operand from the north neighbour or array edge.
- A_out  output  DATA_WIDTH  A_in registered, to the east neighbour.
- B_out  output  DATA_WIDTH  B_in registered, to the south neighbour.
- C_out  output  DATA_WIDTH  accumulator value.

## Operation
- All three outputs come directly from registers. There is no combinational path from input to output.
- Each rising clk with rst high:
  - A_out ← A_in
  - B_out ← B_in
  - C_out ← acc(C_out, A_in × B_in)
- Operands are unsigned.
- The product is formed at full 2·DATA_WIDTH width.
- Default acc (see Configuration):
  - The low DATA_WIDTH bits of the product are added to C_out, modulo 2^DATA_WIDTH.
  - Product high bits and the carry-out are discarded.
- There are no valid or enable signals. The PE accumulates every cycle.
  - An operand of 0 leaves C_out unchanged; this is how idle cycles are inserted.
  - The accumulator is cleared only by reset.
- While rst is low, A_out = B_out = C_out = 0, regardless of clk or inputs.

## Timing
- Reset value of every output: 0. Outputs go to 0 asynchronously on the falling edge of rst.
- A/B forwarding latency: 1 cycle per PE. An operand entering PE k at edge n leaves PE k+1 after edge n+1.
- Accumulate latency: 1 cycle. Inputs sampled at edge n are reflected in C_out after edge n.
- Reset release: the first edge with rst high performs a normal update starting from C_out = 0.
- Reset asserted mid-accumulation discards the partial sum. No other state survives reset.

## Configuration
- Macro: TEST_MAC_SATURATE_EN.
- Undefined (default): modulo-2^DATA_WIDTH wrap-around accumulation, as above.
- Defined:
  - Unsigned saturating accumulation: if the full product ≥ 2^DATA_WIDTH, or the sum carries out, C_out ← all ones.
  - Once saturated, C_out stays all ones until reset, because any nonzero addend keeps it saturated.
  - A/B forwarding is unaffected.

## Structure
- Package test_mac_pkg holds:
  - DATA_WIDTH_DEFAULT = 32
  - typedef data_t (logic [DATA_WIDTH_DEFAULT-1:0])
  - typedef prod_t (double width)
- One sub-module, mac_accumulate: purely combinational.
  - Inputs: acc, a, b.
  - Output: next_acc.
  - Contains the multiply and the wrap/saturate logic selected by TEST_MAC_SATURATE_EN.
- test_mac holds the three registers and instantiates mac_accumulate once.
- Arrays are built by chaining test_mac instances. No array logic lives inside the PE.

## Test plan
- Reset: drive A_in=7, B_in=9, clock, then pull rst low between edges → A_out, B_out, C_out read 0 immediately and stay 0 through further edges while rst is low.
- Basic MAC: after reset release, hold A_in=3, B_in=5 for 3 edges → A_out=3, B_out=5; C_out reads 15, 30, 45.
- Idle hold: from C_out=45, drive A_in=0, B_in=1234 for 4 edges → C_out stays 45; B_out=1234.
- Sum overflow:
  - Setup: A_in=0xFFFF_FFFF, B_in=1 for one edge, then A_in=2, B_in=1.
  - Default build: C_out = 0xFFFF_FFFF, then 0x0000_0001.
  - With TEST_MAC_SATURATE_EN: C_out = 0xFFFF_FFFF, then 0xFFFF_FFFF.
- Product overflow: A_in=0x0001_0000, B_in=0x0001_0000 from C_out=0 → default C_out stays 0; saturate build C_out = 0xFFFF_FFFF.
- Two-PE chain (second PE fed by the first's A_out/B_out):
  - Stimulus: A_in=2, B_in=4 for one edge, then 0/0.
  - PE1: C_out=8 after edge 1.
  - PE2: C_out=0 after edge 1, 8 after edge 2.
  - PE2's A_out=2, B_out=4 after edge 2.

Source files
------------

// File: rtl/test_mac_pkg.sv
// Shared widths and types for the systolic-array processing element.
// Optional saturating accumulation is selected with TEST_MAC_SATURATE_EN.
package test_mac_pkg;

  localparam int DATA_WIDTH_DEFAULT = 32;

  typedef logic [DATA_WIDTH_DEFAULT-1:0]   data_t;
  typedef logic [2*DATA_WIDTH_DEFAULT-1:0] prod_t;

endpackage

// File: rtl/mac_accumulate.sv
// Combinational multiply-accumulate step: next_acc = acc + a*b (unsigned).
// Wraps modulo 2^DATA_WIDTH by default; saturates when TEST_MAC_SATURATE_EN is defined.
module mac_accumulate
  import test_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] next_acc
);

`ifdef TEST_MAC_SATURATE_EN
  logic [2*DATA_WIDTH-1:0] prod_s;
  logic [DATA_WIDTH:0]     sum_s;

  // Full-width product; any high product bit or adder carry pins the result at all ones.
  always_comb begin
    prod_s = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
    sum_s  = {1'b0, acc} + {1'b0, prod_s[DATA_WIDTH-1:0]};
    if ((prod_s[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{1'b0}}) || sum_s[DATA_WIDTH]) begin
      next_acc = {DATA_WIDTH{1'b1}};
    end else begin
      next_acc = sum_s[DATA_WIDTH-1:0];
    end
  end
`else
  logic [DATA_WIDTH-1:0] prod_lo_s;

  // Only the low product bits can reach a wrapping accumulator, so the high half is never built.
  always_comb begin
    prod_lo_s = a * b;
    next_acc  = acc + prod_lo_s;
  end
`endif

endmodule

// File: rtl/test_mac.sv
// Systolic-array PE: registers A east, B south, and accumulates A*B into C_out.
// Accumulate behaviour (wrap or saturate) follows TEST_MAC_SATURATE_EN in mac_accumulate.
module test_mac
  import test_mac_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic [DATA_WIDTH-1:0] A_out,
  output logic [DATA_WIDTH-1:0] B_out,
  output logic [DATA_WIDTH-1:0] C_out
);

  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] next_acc_s;

  mac_accumulate #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_acc (
    .acc      (c_q),
    .a        (A_in),
    .b        (B_in),
    .next_acc (next_acc_s)
  );

  // No enables: every edge forwards operands and accumulates.
  always_comb begin
    a_d = A_in;
    b_d = B_in;
    c_d = next_acc_s;
  end

  // State registers; rst low clears everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= {DATA_WIDTH{1'b0}};
      b_q <= {DATA_WIDTH{1'b0}};
      c_q <= {DATA_WIDTH{1'b0}};
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
    end
  end

  assign A_out = a_q;
  assign B_out = b_q;
  assign C_out = c_q;

endmodule

// File: tb/tb_test_mac.sv
// Directed bench for test_mac: two chained PEs, expected values hand-computed.
// Overflow expectations follow TEST_MAC_SATURATE_EN.
module tb_test_mac;

  logic        clk;
  logic        rst;
  logic [31:0] a_in, b_in;
  logic [31:0] a1_out, b1_out, c1_out;
  logic [31:0] a2_out, b2_out, c2_out;

  int n_checks;
  int n_fail;

  test_mac #(.DATA_WIDTH(32)) u_pe1 (
    .clk   (clk),
    .rst   (rst),
    .A_in  (a_in),
    .B_in  (b_in),
    .A_out (a1_out),
    .B_out (b1_out),
    .C_out (c1_out)
  );

  test_mac #(.DATA_WIDTH(32)) u_pe2 (
    .clk   (clk),
    .rst   (rst),
    .A_in  (a1_out),
    .B_in  (b1_out),
    .A_out (a2_out),
    .B_out (b2_out),
    .C_out (c2_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b0;
    a_in = 32'd0;
    b_in = 32'd0;
    #2;
    check("reset_a", a1_out, 32'd0);
    check("reset_b", b1_out, 32'd0);
    check("reset_c", c1_out, 32'd0);
    rst = 1'b1;

    // Load some state, then assert reset between edges
    a_in = 32'd7;
    b_in = 32'd9;
    tick();
    check("pre_reset_c", c1_out, 32'd63);
    check("pre_reset_a", a1_out, 32'd7);
    rst = 1'b0;
    #1;
    check("async_rst_a", a1_out, 32'd0);
    check("async_rst_b", b1_out, 32'd0);
    check("async_rst_c", c1_out, 32'd0);
    tick();
    tick();
    check("held_rst_a", a1_out, 32'd0);
    check("held_rst_c", c1_out, 32'd0);
    rst = 1'b1;

    // Basic MAC
    a_in = 32'd3;
    b_in = 32'd5;
    tick();
    check("mac1_c", c1_out, 32'd15);
    tick();
    check("mac2_c", c1_out, 32'd30);
    tick();
    check("mac3_c", c1_out, 32'd45);
    check("mac_a", a1_out, 32'd3);
    check("mac_b", b1_out, 32'd5);

    // Idle hold
    a_in = 32'd0;
    b_in = 32'd1234;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_c", c1_out, 32'd45);
    end
    check("idle_b", b1_out, 32'd1234);
    check("idle_a", a1_out, 32'd0);

    // Sum overflow
    pulse_reset();
    a_in = 32'hFFFF_FFFF;
    b_in = 32'd1;
    tick();
    check("sum_ovf1_c", c1_out, 32'hFFFF_FFFF);
    a_in = 32'd2;
    b_in = 32'd1;
    tick();
`ifdef TEST_MAC_SATURATE_EN
    check("sum_ovf2_c", c1_out, 32'hFFFF_FFFF);
`else
    check("sum_ovf2_c", c1_out, 32'h0000_0001);
`endif

    // Product overflow
    pulse_reset();
    a_in = 32'h0001_0000;
    b_in = 32'h0001_0000;
    tick();
`ifdef TEST_MAC_SATURATE_EN
    check("prod_ovf_c", c1_out, 32'hFFFF_FFFF);
`else
    check("prod_ovf_c", c1_out, 32'd0);
`endif
    check("prod_ovf_a", a1_out, 32'h0001_0000);

    // Two-PE chain
    pulse_reset();
    a_in = 32'd2;
    b_in = 32'd4;
    tick();
    check("chain_e1_pe1_c", c1_out, 32'd8);
    check("chain_e1_pe2_c", c2_out, 32'd0);
    check("chain_e1_pe2_a", a2_out, 32'd0);
    a_in = 32'd0;
    b_in = 32'd0;
    tick();
    check("chain_e2_pe1_c", c1_out, 32'd8);
    check("chain_e2_pe2_c", c2_out, 32'd8);
    check("chain_e2_pe2_a", a2_out, 32'd2);
    check("chain_e2_pe2_b", b2_out, 32'd4);
    tick();
    check("chain_e3_pe2_c", c2_out, 32'd8);
    check("chain_e3_pe2_a", a2_out, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
